// File: rtl/keypad_scan_cntr.sv
// keypad_scan_cntr: 4x4 matrix keypad scanner with debounce.
// Drives active-low columns one at a time and reads active-low rows.
// A single key is tracked and reported as {row_idx, col_idx}, together with
// a level valid and one-clk press/release pulses.
// Optional feature macro: KEYPAD_REPEAT_EN. When it is defined, key_pedge
// repeats while the key is held (REPEAT_DELAY, then every REPEAT_RATE ticks).
// Outputs carry no handshake: key_valid is a level, and key_pedge/key_nedge
// are single-clk strobes that downstream logic samples every clk.
module keypad_scan_cntr #(
  parameter int SCAN_DIV_BITS  = 17,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_DELAY   = 400,
  parameter int REPEAT_RATE    = 80,
`endif
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_pedge,
  output logic       key_nedge,
  output logic [1:0] fsm_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [3:0]               row_s1, row_s2;
  logic [SCAN_DIV_BITS-1:0] div_cnt;
  logic                     tick;
  logic [1:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [1:0]               lat_row, lat_col;
  logic [3:0]               row_low;
  logic                     one_hit, same_hit;
  logic [1:0]               row_idx, col_idx;
  logic                     rep_fire;

  assign fsm_state = state;
  assign tick      = &div_cnt;

  // Two-stage synchronizer for the asynchronous row pins (idle = all high).
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // Free-running scan divider; tick marks the clk on which it wraps to 0.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) div_cnt <= '0;
    else         div_cnt <= div_cnt + SCAN_DIV_BITS'(1);
  end

  // Row decode: only a single low row counts as a hit; several low rows are
  // treated as idle because ghost keys cannot be resolved.
  always_comb begin
    row_low  = ~row_s2;
    one_hit  = (row_low != 4'h0) && ((row_low & (row_low - 4'd1)) == 4'h0);
    row_idx  = 2'd0;
    case (row_low)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    col_idx = 2'd0;
    case (col)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    same_hit = one_hit && (row_idx == lat_row);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY) + 1;
  localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_armed;

  assign rep_fire = tick && (state == PRESSED) && one_hit &&
                    (rep_cnt >= (rep_armed ? REP_RATE_LAST : REP_DELAY_LAST));

  // Repeat timer: counts held ticks in PRESSED, cleared in any other state so
  // each entry into PRESSED (including a release bounce) restarts the delay.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (tick) begin
      if (state != PRESSED) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b0;
      end else if (one_hit) begin
        if (rep_fire) begin
          rep_cnt   <= '0;
          rep_armed <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Scan/debounce FSM; every decision is taken on tick only. Column rotation
  // is 1110 -> 1101 -> 1011 -> 0111 and freezes while a key is tracked.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state     <= SCAN;
      col       <= 4'b1110;
      cnt       <= '0;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      key_value <= 4'h0;
      key_valid <= 1'b0;
      key_pedge <= 1'b0;
      key_nedge <= 1'b0;
    end else begin
      key_pedge <= 1'b0;
      key_nedge <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (one_hit) begin
              lat_row <= row_idx;
              lat_col <= col_idx;
              cnt     <= CNT_W'(1);
              state   <= DEBOUNCE;
            end else begin
              col <= {col[2:0], col[3]};
            end
          end
          DEBOUNCE: begin
            if (same_hit) begin
              if (cnt >= DB_LAST) begin
                state     <= PRESSED;
                cnt       <= '0;
                key_value <= {lat_row, lat_col};
                key_valid <= 1'b1;
                key_pedge <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              cnt   <= '0;
              state <= SCAN;
              col   <= {col[2:0], col[3]};
            end
          end
          PRESSED: begin
            if (!one_hit) begin
              cnt   <= CNT_W'(1);
              state <= RELEASE;
            end else if (rep_fire) begin
              key_pedge <= 1'b1;
            end
          end
          default: begin // RELEASE
            // Any single low row while releasing is taken as the contact
            // closing again (the column is frozen on the tracked key).
            if (one_hit) begin
              cnt   <= '0;
              state <= PRESSED;
            end else if (cnt >= DB_LAST) begin
              cnt       <= '0;
              state     <= SCAN;
              col       <= {col[2:0], col[3]};
              key_valid <= 1'b0;
              key_nedge <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_cntr.sv
// tb_keypad_scan_cntr: directed bench for keypad_scan_cntr with a keypad
// model on the pins, a tick-level behavioural reference checked every clk,
// and literal expectations at the key points of each scenario.
module tb_keypad_scan_cntr;

  localparam int SDB  = 4;
  localparam int DB   = 4;
  localparam int TICK = 16;
`ifdef KEYPAD_REPEAT_EN
  localparam int RD = 6;
  localparam int RR = 3;
`endif

  logic       clk = 1'b0;
  logic       reset_p;
  logic [3:0] row, col, key_value;
  logic       key_valid, key_pedge, key_nedge;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int pedge_cnt = 0;
  int nedge_cnt = 0;

  // keypad pins: one pressed key pulls its row low while its column is low
  logic       key_down;
  int         key_r, key_c;
  logic       force_en;
  logic [3:0] force_row;

  // clock / reset block
  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    if (force_en) row = force_row;
    else if (key_down && (col[key_c] == 1'b0)) row[key_r] = 1'b0;
  end

  keypad_scan_cntr #(
    .SCAN_DIV_BITS (SDB),
`ifdef KEYPAD_REPEAT_EN
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR),
`endif
    .DEBOUNCE_TICKS(DB)
  ) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .row      (row),
    .col      (col),
    .key_value(key_value),
    .key_valid(key_valid),
    .key_pedge(key_pedge),
    .key_nedge(key_nedge),
    .fsm_state(fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference (tick level) ----------------
  int         m_div, m_col_pos, m_cand_r, m_cand_c, m_streak, m_open, m_rep, m_reps;
  bit         m_locked, m_held;
  logic [3:0] m_s1, m_s2;
  logic [3:0] e_value;
  logic       e_valid, e_pedge, e_nedge;

  always @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      m_div = 0; m_col_pos = 0; m_locked = 0; m_held = 0;
      m_cand_r = 0; m_cand_c = 0; m_streak = 0; m_open = 0; m_rep = 0; m_reps = 0;
      m_s1 = 4'hF; m_s2 = 4'hF;
      e_value = 4'h0; e_valid = 1'b0; e_pedge = 1'b0; e_nedge = 1'b0;
    end else begin : model_step
      bit is_tick, one;
      int nlow, ridx;
      is_tick = (m_div == TICK - 1);
      m_div   = (m_div + 1) % TICK;
      nlow = 0; ridx = 0;
      for (int i = 0; i < 4; i++) if (!m_s2[i]) begin nlow++; ridx = i; end
      one = (nlow == 1);
      e_pedge = 1'b0;
      e_nedge = 1'b0;
      if (is_tick) begin
        if (!m_locked) begin
          if (one) begin
            m_locked = 1; m_cand_r = ridx; m_cand_c = m_col_pos; m_streak = 1;
          end else begin
            m_col_pos = (m_col_pos + 1) % 4;
          end
        end else if (!m_held) begin
          if (one && ridx == m_cand_r) begin
            m_streak++;
            if (m_streak == DB) begin
              m_held = 1; m_open = 0; m_rep = 0; m_reps = 0;
              e_valid = 1'b1; e_pedge = 1'b1;
              e_value = 4'(m_cand_r * 4 + m_cand_c);
            end
          end else begin
            m_locked = 0;
            m_col_pos = (m_col_pos + 1) % 4;
          end
        end else if (m_open == 0) begin
          if (one) begin
`ifdef KEYPAD_REPEAT_EN
            m_rep++;
            if (m_rep == ((m_reps == 0) ? RD : RR)) begin
              e_pedge = 1'b1; m_rep = 0; m_reps++;
            end
`endif
          end else begin
            m_open = 1;
          end
        end else begin
          if (one) begin
            m_open = 0; m_rep = 0; m_reps = 0;
          end else begin
            m_open++;
            if (m_open == DB) begin
              m_held = 0; m_locked = 0; m_open = 0;
              e_valid = 1'b0; e_nedge = 1'b1;
              m_col_pos = (m_col_pos + 1) % 4;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = row;
    end
  end

  function automatic logic [3:0] col_of(input int pos);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << pos;
    return ~one_hot;
  endfunction

  // ---------------- scoreboard: compare every clk ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("cyc_col",   col,       col_of(m_col_pos));
      check("cyc_value", key_value, e_value);
      check("cyc_valid", key_valid, e_valid);
      check("cyc_pedge", key_pedge, e_pedge);
      check("cyc_nedge", key_nedge, e_nedge);
    end
    if (key_pedge === 1'b1) pedge_cnt++;
    if (key_nedge === 1'b1) nedge_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // which: 0 = key_pedge, 1 = key_nedge, 2 = col == val
  task automatic wait_evt(input int which, input logic [3:0] val, input int limit, input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < limit && !hit; n++) begin
      @(negedge clk);
      case (which)
        0:       hit = (key_pedge === 1'b1);
        1:       hit = (key_nedge === 1'b1);
        default: hit = (col === val);
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: event not seen within %0d clk, col=%b valid=%b", name, limit, col, key_valid);
    end
  endtask

  task automatic press(input int r, input int c);
    key_r = r; key_c = c; key_down = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int p0, n0, reps_exp;
    logic [3:0] scan_seq [4];
    scan_seq[0] = 4'b1101; scan_seq[1] = 4'b1011; scan_seq[2] = 4'b0111; scan_seq[3] = 4'b1110;
    reset_p = 1'b1; key_down = 1'b0; key_r = 0; key_c = 0;
    force_en = 1'b0; force_row = 4'hF;
    step(1);
    mon_en = 1'b1;
    step(2);
    reset_p = 1'b0;

    // 1: reset values and free scan
    check("rst_col",   col,       4'b1110);
    check("rst_value", key_value, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_pedge", key_pedge, 1'b0);
    check("rst_nedge", key_nedge, 1'b0);
    for (int i = 0; i < 4; i++) wait_evt(2, scan_seq[i], TICK + 4, "scan_step");

    // 2: key row1/col2 detected
    step(1);
    press(1, 2);
    wait_evt(0, 4'h0, TICK * 10, "t2_press");
    check("t2_value", key_value, 4'h6);
    check("t2_valid", key_valid, 1'b1);
    check("t2_col",   col,       4'b1011);
    @(negedge clk);
    check("t2_pedge_1clk", key_pedge, 1'b0);

    // 3: short open is absorbed, long open releases
    step(1);
    p0 = pedge_cnt; n0 = nedge_cnt;
    key_down = 1'b0;
    step(2 * TICK);
    key_down = 1'b1;
    step(3 * TICK);
    check("t3_no_nedge", nedge_cnt - n0, 0);
    check("t3_no_pedge", pedge_cnt - p0, 0);
    check("t3_valid",    key_valid, 1'b1);
    key_down = 1'b0;
    wait_evt(1, 4'h0, TICK * 8, "t3_release");
    check("t3_valid_low", key_valid, 1'b0);
    check("t3_col",       col,       4'b0111);
    check("t3_value_kept", key_value, 4'h6);

    // 4: bounce on col0/row3, then two rows low
    wait_evt(2, 4'b1110, TICK * 2, "t4_col0");
    step(1);
    p0 = pedge_cnt;
    press(3, 0);
    step(2 * TICK);
    key_down = 1'b0;
    step(20);
    check("t4_bounce_pedge", pedge_cnt - p0, 0);
    check("t4_bounce_col",   col,       4'b1101);
    check("t4_bounce_valid", key_valid, 1'b0);
    force_row = 4'b0101; force_en = 1'b1;
    step(6 * TICK);
    force_en = 1'b0;
    check("t4_ghost_pedge", pedge_cnt - p0, 0);
    check("t4_ghost_valid", key_valid, 1'b0);

    // 5: reset while a key is held
    step(1);
    press(2, 3);
    wait_evt(0, 4'h0, TICK * 12, "t5_press");
    check("t5_value", key_value, 4'hB);
    step(40);
    reset_p = 1'b1;
    #1;
    check("t5_rst_col",   col,       4'b1110);
    check("t5_rst_valid", key_valid, 1'b0);
    check("t5_rst_value", key_value, 4'h0);
    check("t5_rst_pedge", key_pedge, 1'b0);
    step(3);
    reset_p = 1'b0;
    p0 = pedge_cnt;
    wait_evt(0, 4'h0, TICK * 12, "t5_redetect");
    step(1);
    check("t5_one_pedge", pedge_cnt - p0, 1);
    check("t5_value2",    key_value, 4'hB);
    key_down = 1'b0;
    wait_evt(1, 4'h0, TICK * 8, "t5_release");

    // 6: long hold, repeat only with the feature enabled
    step(1);
    press(0, 1);
    wait_evt(0, 4'h0, TICK * 12, "t6_press");
    step(1);
    p0 = pedge_cnt;
    step(19 * TICK + 6);
`ifdef KEYPAD_REPEAT_EN
    reps_exp = 5;
`else
    reps_exp = 0;
`endif
    check("t6_repeat_count", pedge_cnt - p0, reps_exp);
    check("t6_valid", key_valid, 1'b1);
    check("t6_value", key_value, 4'h1);
    key_down = 1'b0;
    wait_evt(1, 4'h0, TICK * 8, "t6_release");
    check("t6_value_kept", key_value, 4'h1);
    check("t6_valid_low",  key_valid, 1'b0);

    step(2);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
